// File: rtl/sequenciador_giro_servo.sv
// Quarter-turn sequencer for the continuous-rotation servo of the cube arm.
// Spins for N quarter-turn periods, holds a settle pause, then pulses pronto.
module sequenciador_giro_servo #(
   parameter int CICLOS_QUARTO = 12_500_000,
   parameter int CICLOS_PAUSA  = 2_500_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [1:0] quartos,
   input  logic       parar,
   output logic       posicao,
   output logic       ocupado,
   output logic       pronto,
   output logic [1:0] restantes,
   output logic [1:0] db_estado
);

   localparam int MAX_CICLOS = (CICLOS_QUARTO > CICLOS_PAUSA) ? CICLOS_QUARTO : CICLOS_PAUSA;
   localparam int TW         = $clog2(MAX_CICLOS);
   localparam logic [TW-1:0] FIM_QUARTO = TW'(CICLOS_QUARTO - 1);
   localparam logic [TW-1:0] FIM_PAUSA  = TW'(CICLOS_PAUSA - 1);

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      GIRANDO = 2'b01,
      PAUSA   = 2'b10,
      FIM     = 2'b11
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    restantes_q, restantes_d;
   logic          posicao_q, posicao_d;
   logic          ocupado_q, ocupado_d;
   logic          pronto_q, pronto_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         timer_q     <= '0;
         restantes_q <= 2'd0;
         posicao_q   <= 1'b0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         timer_q     <= timer_d;
         restantes_q <= restantes_d;
         posicao_q   <= posicao_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
      end
   end

   // Outputs are computed for the state being entered so they can be registered.
   always_comb begin
      estado_d    = estado_q;
      timer_d     = timer_q;
      restantes_d = restantes_q;
      posicao_d   = posicao_q;
      ocupado_d   = ocupado_q;
      pronto_d    = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            if (iniciar) begin
               if (quartos != 2'd0) begin
                  estado_d    = GIRANDO;
                  timer_d     = '0;
                  restantes_d = quartos;
                  posicao_d   = 1'b1;
                  ocupado_d   = 1'b1;
               end else begin
                  estado_d = FIM;
                  pronto_d = 1'b1;
               end
            end
         end
         GIRANDO: begin
            if (parar || (timer_q == FIM_QUARTO && restantes_q == 2'd1)) begin
               // Abort and the final quarter share the same exit into the pause.
               estado_d    = PAUSA;
               timer_d     = '0;
               restantes_d = 2'd0;
               posicao_d   = 1'b0;
            end else if (timer_q == FIM_QUARTO) begin
               timer_d     = '0;
               restantes_d = restantes_q - 2'd1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         PAUSA: begin
            if (timer_q == FIM_PAUSA) begin
               estado_d  = FIM;
               timer_d   = '0;
               ocupado_d = 1'b0;
               pronto_d  = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         FIM: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   assign posicao   = posicao_q;
   assign ocupado   = ocupado_q;
   assign pronto    = pronto_q;
   assign restantes = restantes_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_giro_servo.sv
// Directed bench for sequenciador_giro_servo with CICLOS_QUARTO=10, CICLOS_PAUSA=4.
module tb_sequenciador_giro_servo;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [1:0] quartos;
   logic       parar;
   logic       posicao;
   logic       ocupado;
   logic       pronto;
   logic [1:0] restantes;
   logic [1:0] db_estado;

   int npass;
   int ntot;

   // Per-cycle capture: index n = sample taken n negedges after the start edge.
   logic [63:0] pos_v;
   logic [63:0] ocu_v;
   logic [63:0] pro_v;
   logic [1:0]  res_a [64];
   logic [1:0]  db_a  [64];

   sequenciador_giro_servo #(
      .CICLOS_QUARTO(10),
      .CICLOS_PAUSA (4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .iniciar  (iniciar),
      .quartos  (quartos),
      .parar    (parar),
      .posicao  (posicao),
      .ocupado  (ocupado),
      .pronto   (pronto),
      .restantes(restantes),
      .db_estado(db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] faixa(input int primeiro, input int ultimo);
      logic [63:0] m;
      m = '0;
      for (int i = primeiro; i <= ultimo; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Issue a command at edge k, then record ncyc samples; optional abort / extra iniciar injections.
   task automatic run_cmd(input logic [1:0] q, input int ncyc, input int parar_at,
                          input int ini_at1, input int ini_at2);
      pos_v = '0; ocu_v = '0; pro_v = '0;
      for (int i = 0; i < 64; i++) begin
         res_a[i] = 2'd0;
         db_a[i]  = 2'd0;
      end
      @(negedge clock);
      iniciar = 1'b1;
      quartos = q;
      @(posedge clock);
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clock);
         pos_v[n] = posicao;
         ocu_v[n] = ocupado;
         pro_v[n] = pronto;
         res_a[n] = restantes;
         db_a[n]  = db_estado;
         parar    = (n == parar_at);
         iniciar  = (n == ini_at1) || (n == ini_at2);
         quartos  = iniciar ? 2'd3 : q;
      end
      iniciar = 1'b0;
      parar   = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      ntot++;
      if ({posicao, ocupado, pronto, restantes, db_estado} !== 7'b0)
         $display("FAIL reset_async: got %b required 0000000", {posicao, ocupado, pronto, restantes, db_estado});
      else npass++;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      parar = 1'b1;
      repeat (5) @(negedge clock);
      parar = 1'b0;
      ntot++;
      if ({posicao, ocupado, pronto, restantes, db_estado} !== 7'b0)
         $display("FAIL reset_idle: got %b required 0000000", {posicao, ocupado, pronto, restantes, db_estado});
      else npass++;
   endtask

   task automatic test_um_quarto();
      run_cmd(2'd1, 24, 0, 0, 0);
      ntot++;
      if (pos_v !== faixa(1, 10)) $display("FAIL q1_posicao: got %h required %h", pos_v, faixa(1, 10));
      else npass++;
      ntot++;
      if (ocu_v !== faixa(1, 14)) $display("FAIL q1_ocupado: got %h required %h", ocu_v, faixa(1, 14));
      else npass++;
      ntot++;
      if (pro_v !== faixa(15, 15)) $display("FAIL q1_pronto: got %h required %h", pro_v, faixa(15, 15));
      else npass++;
      ntot++;
      if ({db_a[1], db_a[11], db_a[15], db_a[16]} !== 8'b01_10_11_00)
         $display("FAIL q1_estados: got %b required 01101100", {db_a[1], db_a[11], db_a[15], db_a[16]});
      else npass++;
   endtask

   task automatic test_tres_quartos();
      run_cmd(2'd3, 40, 0, 0, 0);
      ntot++;
      if (pos_v !== faixa(1, 30)) $display("FAIL q3_posicao: got %h required %h", pos_v, faixa(1, 30));
      else npass++;
      ntot++;
      if ({res_a[1], res_a[10], res_a[11], res_a[20], res_a[21], res_a[30], res_a[31]} !== 14'b11_11_10_10_01_01_00)
         $display("FAIL q3_restantes: got %b required 11111010010100",
                  {res_a[1], res_a[10], res_a[11], res_a[20], res_a[21], res_a[30], res_a[31]});
      else npass++;
      ntot++;
      if (pro_v !== faixa(35, 35)) $display("FAIL q3_pronto: got %h required %h", pro_v, faixa(35, 35));
      else npass++;
      ntot++;
      if (ocu_v !== faixa(1, 34)) $display("FAIL q3_ocupado: got %h required %h", ocu_v, faixa(1, 34));
      else npass++;
   endtask

   task automatic test_iniciar_ignorado();
      run_cmd(2'd2, 40, 0, 5, 15);
      ntot++;
      if (pos_v !== faixa(1, 20)) $display("FAIL ign_posicao: got %h required %h", pos_v, faixa(1, 20));
      else npass++;
      ntot++;
      if (pro_v !== faixa(25, 25)) $display("FAIL ign_pronto: got %h required %h", pro_v, faixa(25, 25));
      else npass++;
      ntot++;
      if (ocu_v !== faixa(1, 24)) $display("FAIL ign_ocupado: got %h required %h", ocu_v, faixa(1, 24));
      else npass++;
   endtask

   task automatic test_parar();
      run_cmd(2'd3, 24, 7, 0, 0);
      ntot++;
      if (pos_v !== faixa(1, 7)) $display("FAIL parar_posicao: got %h required %h", pos_v, faixa(1, 7));
      else npass++;
      ntot++;
      if (ocu_v !== faixa(1, 11)) $display("FAIL parar_ocupado: got %h required %h", ocu_v, faixa(1, 11));
      else npass++;
      ntot++;
      if (pro_v !== faixa(12, 12)) $display("FAIL parar_pronto: got %h required %h", pro_v, faixa(12, 12));
      else npass++;
      ntot++;
      if ({res_a[7], res_a[8], db_a[8]} !== 6'b11_00_10)
         $display("FAIL parar_restantes: got %b required 110010", {res_a[7], res_a[8], db_a[8]});
      else npass++;
   endtask

   task automatic test_reset_em_giro();
      logic [63:0] pro_pos;
      @(negedge clock);
      iniciar = 1'b1;
      quartos = 2'd3;
      @(posedge clock);
      @(negedge clock);
      iniciar = 1'b0;
      repeat (11) @(negedge clock);
      ntot++;
      if (posicao !== 1'b1) $display("FAIL rst_giro_pre: posicao got %b required 1", posicao);
      else npass++;
      #2 reset = 1'b1;
      #1;
      ntot++;
      if ({posicao, ocupado, pronto, restantes, db_estado} !== 7'b0)
         $display("FAIL rst_giro_async: got %b required 0000000", {posicao, ocupado, pronto, restantes, db_estado});
      else npass++;
      @(negedge clock);
      reset = 1'b0;
      pro_pos = '0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clock);
         pro_pos[n] = pronto | posicao | ocupado;
      end
      ntot++;
      if (pro_pos !== 64'd0) $display("FAIL rst_giro_sem_pronto: activity got %h required 0", pro_pos);
      else npass++;
   endtask

   task automatic test_zero_quartos();
      run_cmd(2'd0, 10, 0, 0, 0);
      ntot++;
      if (pro_v !== faixa(1, 1)) $display("FAIL q0_pronto: got %h required %h", pro_v, faixa(1, 1));
      else npass++;
      ntot++;
      if ((pos_v | ocu_v) !== 64'd0) $display("FAIL q0_sem_giro: got %h required 0", pos_v | ocu_v);
      else npass++;
      ntot++;
      if ({db_a[1], db_a[2]} !== 4'b11_00) $display("FAIL q0_estados: got %b required 1100", {db_a[1], db_a[2]});
      else npass++;
   endtask

   initial begin
      npass   = 0;
      ntot    = 0;
      reset   = 1'b0;
      iniciar = 1'b0;
      quartos = 2'd0;
      parar   = 1'b0;
      test_reset();
      test_um_quarto();
      test_tres_quartos();
      test_iniciar_ignorado();
      test_parar();
      test_reset_em_giro();
      test_zero_quartos();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
